// File: rtl/mem_pkg.sv
// Shared sizing and word type for the memory stage and its data array.
package mem_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_BITS  = 8;
  localparam int unsigned DEPTH      = 256;

  typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed register array: synchronous active-low clear, one write port,
// one combinational read port.
module dmem_array
  import mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  word_t                wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output word_t                rdata
);

  word_t mem_q [DEPTH];

  // Clear every word on reset (reset beats a same-edge write), else write on we.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port is asynchronous, so a same-cycle store shows old data until the edge.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/mem_stage_dmem.sv
// Pipeline memory stage: range-checks the word index, gates stores into the
// data array and returns load data combinationally to writeback.
module mem_stage_dmem
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  is_ld_op_passthrough,
  input  logic                  is_str_op_passthrough,
  input  logic [DATA_WIDTH-1:0] md_passthrough,
  input  logic [DATA_WIDTH-1:0] rd_val_passthrough,
  output logic [DATA_WIDTH-1:0] dmem_val_passthrough
);

  logic                 in_range;
  logic                 we;
  logic [ADDR_BITS-1:0] index;
  word_t                rdata;

  // Upper address bits must be zero; anything else is dropped or reads as 0.
  always_comb begin
    index    = md_passthrough[ADDR_BITS-1:0];
    in_range = (md_passthrough[DATA_WIDTH-1:ADDR_BITS] == '0);
    we       = is_str_op_passthrough && in_range;
  end

  dmem_array u_dmem_array (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (index),
    .wdata (rd_val_passthrough),
    .raddr (index),
    .rdata (rdata)
  );

  // Load data only for an in-range load; otherwise drive zero.
  always_comb begin
    dmem_val_passthrough = (is_ld_op_passthrough && in_range) ? rdata : '0;
  end

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Self-checking bench for mem_stage_dmem: directed scenarios plus random traffic
// against an array-based reference memory.
module tb_mem_stage_dmem;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld;
  logic        str;
  logic [31:0] md;
  logic [31:0] rd_val;
  logic [31:0] dout;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference memory, indexed by integer word address.
  logic [31:0] model [256];

  mem_stage_dmem dut (
    .clk                   (clk),
    .reset                 (reset),
    .is_ld_op_passthrough  (ld),
    .is_str_op_passthrough (str),
    .md_passthrough        (md),
    .rd_val_passthrough    (rd_val),
    .dmem_val_passthrough  (dout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (md=0x%08h ld=%0b str=%0b)",
               tag, obs, exp, md, ld, str);
    end
  endtask

  function automatic logic [31:0] ref_load();
    if (ld && md < 32'd256) return model[md];
    return 32'h0;
  endfunction

  // Apply the effect of the coming edge to the model, then cross it.
  task automatic edge_step();
    if (!reset) begin
      for (int i = 0; i < 256; i++) model[i] = 32'h0;
    end else if (str && md < 32'd256) begin
      model[md] = rd_val;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    #1;
    check_eq(tag, dout, ref_load());
  endtask

  initial begin
    reset = 1'b0; ld = 1'b0; str = 1'b0; md = '0; rd_val = '0;
    edge_step();
    reset = 1'b1;

    // Reset clear
    ld = 1'b1;
    for (int i = 0; i < 256; i++) begin
      md = i;
      #1 check_eq("reset_clear", dout, 32'h0);
    end

    // Fill and readback
    ld = 1'b0; str = 1'b1;
    for (int i = 0; i < 256; i++) begin
      md = i; rd_val = i;
      edge_step();
    end
    str = 1'b0; ld = 1'b1;
    for (int i = 0; i < 256; i++) begin
      md = i;
      #1 check_eq("fill_readback", dout, i);
    end
    str = 1'b1; ld = 1'b0; md = 5; rd_val = 32'hDEAD_BEEF;
    edge_step();
    str = 1'b0; ld = 1'b1;
    #1 check_eq("overwrite", dout, 32'hDEAD_BEEF);

    // Load gating
    ld = 1'b0; md = 10;
    #1 check_eq("gate_ld_low", dout, 32'h0);
    ld = 1'b1;
    #1 check_eq("gate_ld_high", dout, 32'd10);

    // Simultaneous load and store: old data before the edge, new after
    md = 7; rd_val = 32'h55; str = 1'b1;
    #1 check_eq("rbw_before", dout, 32'd7);
    edge_step();
    check_eq("rbw_after", dout, 32'h55);
    str = 1'b0;

    // Out-of-range store and load
    md = 32'h100; rd_val = 32'hAAAA; str = 1'b1;
    #1 check_eq("oor_load", dout, 32'h0);
    edge_step();
    str = 1'b0; md = 0;
    #1 check_eq("oor_mem0", dout, 32'h0);

    // Reset wins over a same-edge store; store lands once reset releases
    md = 3; rd_val = 32'h1234; str = 1'b1; reset = 1'b0;
    edge_step();
    reset = 1'b1;
    #1 check_eq("rst_store_dropped", dout, 32'h0);
    md = 5;
    #1 check_eq("rst_cleared_5", dout, 32'h0);
    md = 3;
    edge_step();
    str = 1'b0;
    #1 check_eq("store_after_rst", dout, 32'h1234);

    // Random traffic against the reference memory
    for (int n = 0; n < 600; n++) begin
      reset  = ($urandom_range(0, 59) != 0);
      ld     = $urandom_range(0, 1);
      str    = $urandom_range(0, 1);
      md     = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 255);
      rd_val = $urandom;
      check_model("rand_pre");
      edge_step();
      check_model("rand_post");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_dmem.md
Name: mem_stage_dmem

Overview:
Pipeline memory stage fused with its word-addressed data memory (256 x 32).
- Takes the load/store strobes, effective address and store data from the execute stage.
- Performs stores into the array on the clock edge.
- Returns load data combinationally to the writeback stage.

Parameters:
DATA_WIDTH, 32, width of a data word and of the store/load data paths
ADDR_BITS, 8, number of address bits used as the word index
DEPTH, 256, number of words (must equal 2**ADDR_BITS)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-low reset
is_ld_op_passthrough  input  1  current instruction is a load
is_str_op_passthrough  input  1  current instruction is a store
md_passthrough  input  32  memory address (word index)
rd_val_passthrough  input  32  store data
dmem_val_passthrough  output  32  load data to writeback

Behaviour:
- Addressing is by word index, not byte address. Index = md_passthrough[ADDR_BITS-1:0].
- In-range condition: md_passthrough[31:ADDR_BITS] == 0.
- Reset: at a rising clk with reset=0, all DEPTH words clear to 0. Stores are suppressed on that edge.
- Reset mid-operation: reset wins over a pending store on the same edge. No partial state survives.
- Store: at a rising clk with reset=1, is_str_op_passthrough=1 and an in-range address, mem[index] <= rd_val_passthrough.
  - Store latency 1 edge; data is visible to a load from the next cycle.
  - An out-of-range store is dropped; memory is unchanged.
- Load: dmem_val_passthrough is combinational, zero cycle latency. It is mem[index] when is_ld_op_passthrough=1 and the address is in range, otherwise 0.
- Neither strobe asserted: no write; output is 0.
- Both strobes asserted in the same cycle:
  - The store executes at the edge.
  - The output shows the pre-write contents (read-before-write) until the edge, then the new value.
- Address or strobe changes between edges: the output follows combinationally. A write occurs only at the edge, with the values present then.
- No handshake or stall: every cycle is accepted.
- Output after reset: 0 for every load until that word is written.
- All data is 32-bit unsigned. There is no byte or halfword access and no sign extension.

Decomposition:
- Shared package mem_pkg holds DATA_WIDTH, ADDR_BITS and DEPTH, and a word typedef (logic [DATA_WIDTH-1:0]).
- One sub-module, dmem_array: synchronous-reset register array with one write port and one combinational read port (clk, reset, we, waddr, wdata, raddr, rdata).
- The top level contains only the address range check, the write-enable gating (store & in-range) and the output mux (load & in-range ? rdata : 0).

Test Plan:
1. Reset clear:
   - Hold reset=0 for 1 edge, then release.
   - Load any address 0..255 -> dmem_val_passthrough=0.
2. Fill and readback:
   - With str=1, for i=0..255, md=i and rd_val=i, one edge each.
   - Then with ld=1, str=0, for i=0..255, md=i -> output=i in the same cycle.
   - Overwrite: store addr 5 value 0xDEADBEEF, then load 5 -> 0xDEADBEEF.
3. Load gating:
   - With ld=0, str=0 and md=10 after storing 10 -> output 0.
   - Raise ld -> output 10 without waiting for an edge.
4. Simultaneous load and store:
   - mem[7]=7; set ld=1, str=1, md=7, rd_val=0x55.
   - Before the edge, output 7; after the edge, output 0x55.
5. Out-of-range address:
   - Store md=0x100 with rd_val=0xAAAA -> mem[0] unchanged.
   - Load md=0x100 -> output 0.
6. Reset during store:
   - With str=1, md=3, rd_val=0x1234 and reset=0 at the same edge -> mem[3]=0.
   - With reset=1 on the next edge, the store takes effect -> load 3 returns 0x1234.
